// File: rtl/mem_subword_if.sv
// Bundle of pipeline-side request/response and memory-side bus signals
// for the MEM-stage sub-word load/store unit.
interface mem_subword_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // The unit itself: accepts pipeline requests, drives the memory bus.
  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // The environment: pipeline MEM stage plus data memory.
  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_subword_unit.sv
// MEM-stage load/store unit: byte-lane store narrowing, sub-word load
// extraction, memory handshake with timeout and error reporting.
//
// state | meaning
// IDLE  | ready for a new access; checks and latches the request
// WAIT  | mem_req held with stable address/lanes until ack or timeout
// RESP  | one-cycle resp_valid pulse with registered data and error code
module mem_subword_unit #(
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset,
  mem_subword_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        accept, mem_done, mem_abort;
  logic [1:0]  chk_err;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  logic [1:0]  lane;
  logic [1:0]  lsize;
  logic        lsext;
  logic        lwe;
  logic [7:0]  cnt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q, resp_rdata_q;
  logic [3:0]  mem_be_q;
  logic [1:0]  resp_err_q;

  // Illegal size outranks misalignment.
  always_comb begin
    chk_err = 2'b00;
    if (bus.req_size == 2'b11)
      chk_err = 2'b10;
    else if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
             (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
      chk_err = 2'b01;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        st_be    = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_rdata[7:0];
    case (lane)
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      2'd3:    ld_byte = bus.mem_rdata[31:24];
      default: ;
    endcase
    ld_half = lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (lsize)
      2'b00:   ld_data = {{24{lsext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{lsext & ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // An ack in the same cycle the counter expires wins over the timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mem_done  = 1'b0;
    mem_abort = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = (chk_err != 2'b00) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          mem_done  = 1'b1;
          state_nxt = RESP;
        end else if (cnt == TO_LAST) begin
          mem_abort = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane         <= 2'b00;
      lsize        <= 2'b00;
      lsext        <= 1'b0;
      lwe          <= 1'b0;
      cnt          <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 2'b00;
    end else begin
      if (accept) begin
        lane         <= bus.req_addr[1:0];
        lsize        <= bus.req_size;
        lsext        <= bus.req_sext;
        lwe          <= bus.req_we;
        cnt          <= 8'd0;
        resp_rdata_q <= 32'd0;
        resp_err_q   <= chk_err;
        if (chk_err == 2'b00) begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= bus.req_we;
          mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
          mem_be_q    <= bus.req_we ? st_be : 4'b1111;
          mem_wdata_q <= bus.req_we ? st_wdata : 32'd0;
        end
      end
      if (mem_done) begin
        mem_req_q    <= 1'b0;
        mem_we_q     <= 1'b0;
        resp_rdata_q <= lwe ? 32'd0 : ld_data;
      end else if (mem_abort) begin
        mem_req_q  <= 1'b0;
        mem_we_q   <= 1'b0;
        resp_err_q <= 2'b11;
        cnt        <= cnt + 8'd1;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.stall      = (state != IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_subword_unit.sv
// Self-checking bench for mem_subword_unit: directed cases plus random
// accesses compared against an arithmetic reference model.
module tb_mem_subword_unit;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails = 0;

  mem_subword_if bus();

  mem_subword_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the lane/extension rules with arithmetic.
  function automatic logic [1:0] m_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 3) return 2'd2;
    if (size == 1 && (addr % 2) != 0) return 2'd1;
    if (size == 2 && (addr % 4) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
    if (!we || size == 2) return 4'd15;
    if (size == 0) return 4'(1 << (addr % 4));
    return ((addr % 4) >= 2) ? 4'd12 : 4'd3;
  endfunction

  function automatic logic [31:0] m_wdata(input logic we, input logic [1:0] size, input logic [31:0] wd);
    if (!we) return 32'd0;
    if (size == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] size, input logic sext,
                                          input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    if (size == 0) begin
      v = (rd >> (8 * (addr % 4))) & 32'hFF;
      if (sext && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rd >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
      if (sext && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One complete access; ack arrives in WAIT cycle ack_delay (>= TIMEOUT: never).
  task automatic access(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_delay);
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    e_err = m_err(size, addr);
    e_rdata = 32'd0;
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (e_err == 2'd0) begin
      for (int c = 0; c < TIMEOUT; c++) begin
        check("mem_req", bus.mem_req, 1);
        check("mem_we", bus.mem_we, we);
        check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
        check("mem_be", bus.mem_be, m_be(we, size, addr));
        check("mem_wdata", bus.mem_wdata, m_wdata(we, size, wd));
        check("stall_wait", bus.stall, 1);
        check("resp_valid_wait", bus.resp_valid, 0);
        check("req_ready_wait", bus.req_ready, 0);
        bus.mem_rdata = (c == ack_delay) ? rd : $urandom;
        bus.mem_ack   = (c == ack_delay);
        if (c > 0) begin
          bus.req_valid = 1'b1;
          bus.req_addr  = $urandom;
          bus.req_size  = 2'($urandom_range(0, 3));
          bus.req_we    = ~we;
        end
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.req_valid = 1'b0;
        if (c == ack_delay) break;
      end
      if (ack_delay < TIMEOUT) begin
        if (!we) e_rdata = m_rdata(size, sext, addr, rd);
      end else begin
        e_err = 2'd3;
      end
    end
    check("resp_valid", bus.resp_valid, 1);
    check("resp_err", bus.resp_err, e_err);
    check("resp_rdata", bus.resp_rdata, e_rdata);
    check("mem_req_resp", bus.mem_req, 0);
    check("stall_resp", bus.stall, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check("resp_valid_drop", bus.resp_valid, 0);
    check("stall_idle", bus.stall, 0);
    check("mem_req_idle", bus.mem_req, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sext  = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed loads and stores.
    access(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0, 32'h80AB_CDEF, 0);
    access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 32'h8123_4567, 0);
    access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'd0, 32'h8123_4567, 0);
    access(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56A5, 32'd0, 0);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_56A5, 32'd0, 1);
    access(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'd0, 0);
    access(1'b0, 2'b10, 1'b1, 32'h0000_0044, 32'd0, 32'hF00D_CAFE, 2);

    // Error requests never reach memory.
    access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0, 32'd0, 0);
    access(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'd0, 32'd0, 0);
    access(1'b1, 2'b11, 1'b0, 32'h0000_0003, 32'h55, 32'd0, 0);

    // Ack in the last allowed cycle succeeds; no ack times out.
    access(1'b0, 2'b00, 1'b0, 32'h0000_3002, 32'd0, 32'h0011_2233, TIMEOUT - 1);
    access(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'd0, 32'h0011_2233, 99);

    // Reset during WAIT abandons the access.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_0100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort_mem_req_on", bus.mem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_mem_req", bus.mem_req, 0);
    check("abort_stall", bus.stall, 0);
    check("abort_resp_valid", bus.resp_valid, 0);
    check("abort_req_ready_rst", bus.req_ready, 0);
    reset = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check("late_ack_resp_valid", bus.resp_valid, 0);
    check("late_ack_mem_req", bus.mem_req, 0);
    check("late_ack_req_ready", bus.req_ready, 1);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'd0, 32'h00C3_0000, 0);

    // Random accesses, including illegal sizes, misalignment and timeouts.
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, int'($urandom_range(0, TIMEOUT + 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
